// File: rtl/difftest_irp_event_gen.sv
`default_nettype none
// ============================================================================
//  Module   : difftest_irp_event_gen
//  Purpose  : Samples the per-core interrupt-pending vector, emits an event
//             only on change (or after reset / enable rising), buffers events
//             in a small FIFO that coalesces its tail when full, and drains
//             them over a valid/ready port.
//  Revision : 1.0 - initial release
// ============================================================================
module difftest_irp_event_gen #(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [9:0]  in_irp,
  input  logic [7:0]  in_coreid,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [9:0]  out_irp,
  output logic [7:0]  out_coreid,
  output logic [7:0]  out_seq,
  output logic [15:0] drop_cnt
);

  localparam int c_AW = $clog2(DEPTH);

  logic [9:0]      r_prev;
  logic            r_base;
  logic            r_enPrev;
  logic [7:0]      r_seq;
  logic [c_AW:0]   r_wrPtr;
  logic [c_AW:0]   r_rdPtr;
  logic [15:0]     r_dropCnt;

  logic [9:0]      r_memIrp  [DEPTH];
  logic [7:0]      r_memCore [DEPTH];
  logic [7:0]      r_memSeq  [DEPTH];

  logic            w_empty;
  logic            w_full;
  logic            w_baseNow;
  logic            w_push;
  logic            w_pop;
  logic            w_coalesce;
  logic [c_AW-1:0] w_wrIdx;
  logic [c_AW-1:0] w_tailIdx;
  logic [c_AW-1:0] w_rdIdx;

  assign w_empty   = (r_wrPtr == r_rdPtr);
  assign w_full    = (r_wrPtr[c_AW] != r_rdPtr[c_AW]) &&
                     (r_wrPtr[c_AW-1:0] == r_rdPtr[c_AW-1:0]);
  // A baseline snapshot is owed after reset and on every enable rising edge.
  assign w_baseNow = r_base || (enable && !r_enPrev);
  assign w_push    = enable && ((in_irp != r_prev) || w_baseNow);
  assign w_pop     = !w_empty && out_ready;
  // Full with no pop frees no slot: the newest snapshot replaces the tail.
  assign w_coalesce = w_push && w_full && !w_pop;
  assign w_wrIdx   = r_wrPtr[c_AW-1:0];
  assign w_tailIdx = r_wrPtr[c_AW-1:0] - c_AW'(1);
  assign w_rdIdx   = r_rdPtr[c_AW-1:0];

  // Head entry; forced to zero while empty so stale storage never shows.
  assign out_valid  = !w_empty;
  assign out_irp    = w_empty ? 10'd0 : r_memIrp[w_rdIdx];
  assign out_coreid = w_empty ? 8'd0  : r_memCore[w_rdIdx];
  assign out_seq    = w_empty ? 8'd0  : r_memSeq[w_rdIdx];
  assign drop_cnt   = r_dropCnt;

  // Control state: change detector, baseline flag, sequence, pointers, drops.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_prev    <= 10'd0;
      r_base    <= 1'b1;
      r_enPrev  <= 1'b0;
      r_seq     <= 8'd0;
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_dropCnt <= 16'd0;
    end else begin
      r_prev   <= in_irp;
      r_enPrev <= enable;
      r_base   <= w_push ? 1'b0 : r_base;
      if (w_push) begin
        r_seq <= r_seq + 8'd1;
      end
      if (w_push && !w_coalesce) begin
        r_wrPtr <= r_wrPtr + (c_AW+1)'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + (c_AW+1)'(1);
      end
      if (w_coalesce && (r_dropCnt != 16'hFFFF)) begin
        r_dropCnt <= r_dropCnt + 16'd1;
      end
    end
  end

  // Entry storage: append at the write pointer, or overwrite tail on coalesce.
  always_ff @(posedge clock) begin
    if (reset && w_push) begin
      r_memIrp[w_coalesce ? w_tailIdx : w_wrIdx]  <= in_irp;
      r_memCore[w_coalesce ? w_tailIdx : w_wrIdx] <= in_coreid;
      r_memSeq[w_coalesce ? w_tailIdx : w_wrIdx]  <= r_seq;
    end
  end

endmodule
`default_nettype wire

// File: doc/difftest_irp_event_gen.md
# difftest_irp_event_gen

Producer side of the non-register interrupt-pending difftest event. It samples the ten per-core interrupt-pending sources every cycle and emits an event only when the pending vector changes, instead of on every cycle. Events are buffered in a small FIFO and drained over a valid/ready port into the DPI sink for the interrupt-pending event. It sits in the per-core difftest glue, between the CSR/AIA/PMU interrupt wiring and the event sink.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, at least 2.

Ports:
- clock  in  1  sole clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  capture enable; low suppresses new events.
- in_irp  in  10  pending vector. Bit mapping: [0] platform MEIP, [1] MTIP, [2] MSIP, [3] SEIP, [4] STIP, [5] VSEIP, [6] VSTIP, [7] AIA MEIP, [8] AIA SEIP, [9] local counter-overflow request.
- in_coreid  in  8  core id, captured with each event.
- out_valid  out  1  head entry available.
- out_ready  in  1  sink accepts head.
- out_irp  out  10  head pending vector, same bit mapping as in_irp.
- out_coreid  out  8  head core id.
- out_seq  out  8  head sequence number.
- drop_cnt  out  16  count of coalesced (overwritten) events; saturates at 16'hFFFF.

## Operation
- The prev register holds the last sampled in_irp. It updates every cycle, independent of enable.
- A flag named base is set by reset and by any enable 0→1 edge.
- A push occurs when enable=1 and either (in_irp != prev) or base=1. base clears on the push it causes.
- A push writes {in_irp, in_coreid, seq} into the FIFO, then increments seq (mod 256).
- Pop occurs when out_valid && out_ready. out_valid = !empty. Outputs show the head entry and stay stable while out_valid && !out_ready.
- Full and push without pop: coalesce. The tail entry is overwritten with the new snapshot and a new seq; seq still increments, so the sink sees a seq gap. drop_cnt increments (saturating). Occupancy is unchanged.
- Full with push and pop in the same cycle: normal push, no coalesce, no drop.
- Empty with push and pop in the same cycle: no pop, because out_valid=0. The entry becomes visible the next cycle; there is no bypass.
- enable=0 while the FIFO is non-empty: draining continues normally.

## Timing
- Reset (reset=0 at an edge) sets prev=0, seq=0, FIFO empty, drop_cnt=0, base=1. Outputs: out_valid=0, out_irp=0, out_coreid=0, out_seq=0.
- A reset asserted mid-operation discards all queued entries. No partial state survives.
- Latency: a change presented in cycle N is pushed at the end of cycle N. out_valid rises in cycle N+1 if the FIFO was empty.
- Throughput: one push and one pop per cycle.
- An input toggle lasting one cycle generates two events: the change, and the return.
- Pointers are log2(DEPTH) bits plus one wrap bit. Full = pointers equal except the wrap bit.

## Test plan
- Baseline after reset: reset low for 2 cycles, then high with enable=1, in_irp=0x000, out_ready=1. Expect exactly one event: irp=0x000, seq=0, out_valid in cycle 2 after release. No further events while the input is steady.
- Single change: in_irp 0x000→0x080 at cycle N, out_ready=1. Expect out_valid in N+1 with irp=0x080, seq=1, held for one cycle only.
- Coalesce: DEPTH=4, out_ready=0, apply 6 distinct changes on consecutive cycles after the baseline. Expect queue contents seq 0,1,2,6, with tail irp equal to the last value, and drop_cnt=3. Then out_ready=1 drains exactly 4 entries.
- Full with simultaneous push and pop: fill to 4 entries, then assert out_ready=1 and apply a change in the same cycle. Expect drop_cnt unchanged, occupancy stays 4, and the new seq appended.
- Enable gating: enable=0, toggle in_irp 0x001→0x003. Expect no events. Then raise enable with the input steady at 0x003. Expect one baseline event irp=0x003.
- Reset mid-drain: 3 entries queued, reset low one cycle. Expect out_valid=0 the next cycle, then a baseline event with seq=0.
